// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared encodings for the metadata-processing pipeline:
//   - cfg_mode values (pass-through, insert, insert + drop-if-zero, reserved)
//   - packet-tracking state encodings (first beat / middle beats)
//   - small helpers for interpreting the mode
// -----------------------------------------------------------------------------
package md_pkg;

   localparam logic [1:0] MD_MODE_PASS   = 2'd0;
   localparam logic [1:0] MD_MODE_INSERT = 2'd1;
   localparam logic [1:0] MD_MODE_DROP0  = 2'd2;
   localparam logic [1:0] MD_MODE_RSVD   = 2'd3;

   typedef enum logic [0:0] {
      ST_FIRST  = 1'b0,
      ST_MIDDLE = 1'b1
   } md_state_e;

   // Every mode except pass-through writes md into tuser; the reserved
   // encoding behaves like plain insert.
   function automatic logic mode_inserts(input logic [1:0] mode);
      return (mode != MD_MODE_PASS);
   endfunction

   // Only the explicit drop mode may discard packets.
   function automatic logic mode_drops(input logic [1:0] mode);
      return (mode == MD_MODE_DROP0);
   endfunction

endpackage

// File: rtl/md_process_pipe_skid.sv
// -----------------------------------------------------------------------------
// axis_skid_reg
// Registered stream stage with a one-entry skid buffer. Gives full
// throughput with a registered in_ready that equals !skid_valid.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_data    in   WIDTH   payload of the upstream beat
//   in_valid   in   1       upstream beat present
//   in_ready   out  1       registered ready (0 during reset, !skid_valid after)
//   out_data   out  WIDTH   registered payload
//   out_valid  out  1       registered valid
//   out_ready  in   1       downstream ready
// -----------------------------------------------------------------------------
module axis_skid_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [WIDTH-1:0] out_data_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] skid_data_r;
   logic             skid_valid_r;
   logic             in_ready_r;

   logic             push_s;
   logic             out_free_s;
   logic [WIDTH-1:0] out_data_n_s;
   logic             out_valid_n_s;
   logic [WIDTH-1:0] skid_data_n_s;
   logic             skid_valid_n_s;

   assign push_s     = in_valid && in_ready_r;
   assign out_free_s = !out_valid_r || out_ready;

   // Next-state of output register and skid entry. A push can only occur
   // while the skid is empty, so "skid drains" and "push" never coincide.
   always_comb begin
      out_data_n_s   = out_data_r;
      out_valid_n_s  = out_valid_r;
      skid_data_n_s  = skid_data_r;
      skid_valid_n_s = skid_valid_r;
      if (out_free_s) begin
         if (skid_valid_r) begin
            out_data_n_s   = skid_data_r;
            out_valid_n_s  = 1'b1;
            skid_valid_n_s = 1'b0;
         end else if (push_s) begin
            out_data_n_s  = in_data;
            out_valid_n_s = 1'b1;
         end else begin
            out_valid_n_s = 1'b0;
         end
      end else begin
         if (push_s) begin
            skid_data_n_s  = in_data;
            skid_valid_n_s = 1'b1;
         end else begin
            skid_valid_n_s = skid_valid_r;
         end
      end
   end

   // State registers; ready is registered as the complement of the next skid occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data_r   <= {WIDTH{1'b0}};
         out_valid_r  <= 1'b0;
         skid_data_r  <= {WIDTH{1'b0}};
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b0;
      end else begin
         out_data_r   <= out_data_n_s;
         out_valid_r  <= out_valid_n_s;
         skid_data_r  <= skid_data_n_s;
         skid_valid_r <= skid_valid_n_s;
         in_ready_r   <= !skid_valid_n_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;

endmodule

// File: rtl/md_process_pipe.sv
// -----------------------------------------------------------------------------
// md_process_pipe
// AXI-Stream metadata stage. On the first beat of each packet a MD_WIDTH-bit
// field at byte MD_OFFSET is captured (bytes outside tkeep read as zero) and
// written into tuser[MD_USER_LSB +: MD_WIDTH] on every beat of the packet.
// In drop mode, packets whose captured field is zero are swallowed.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_*                 input stream (tdata/tkeep/tuser/tvalid/tready/tlast)
//   m_axis_*                 registered output stream
//   cfg_mode                 0 pass, 1 insert, 2 insert+drop-if-zero, 3 as 1
//   stat_pkt_cnt             packets forwarded (emitted tlast beats)
//   stat_drop_cnt            packets dropped
//   stat_byte_cnt            bytes forwarded (popcount of emitted tkeep)
// -----------------------------------------------------------------------------
module md_process_pipe
   import md_pkg::*;
#(
   parameter int DATA_WIDTH  = 256,
   parameter int USER_WIDTH  = 128,
   parameter int MD_OFFSET   = 0,
   parameter int MD_WIDTH    = 32,
   parameter int MD_USER_LSB = 0,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [USER_WIDTH-1:0]   s_axis_tuser,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [USER_WIDTH-1:0]   m_axis_tuser,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   input  logic [1:0]              cfg_mode,
   output logic [CNT_WIDTH-1:0]    stat_pkt_cnt,
   output logic [CNT_WIDTH-1:0]    stat_drop_cnt,
   output logic [CNT_WIDTH-1:0]    stat_byte_cnt
);

   localparam int KEEP_WIDTH    = DATA_WIDTH / 8;
   localparam int MD_BYTES      = MD_WIDTH / 8;
   localparam int PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

   function automatic logic [CNT_WIDTH-1:0] keep_popcount(input logic [KEEP_WIDTH-1:0] keep);
      logic [CNT_WIDTH-1:0] sum;
      sum = {CNT_WIDTH{1'b0}};
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         sum = sum + CNT_WIDTH'(keep[i]);
      end
      return sum;
   endfunction

   md_state_e              state_r;
   md_state_e              state_n_s;
   logic [1:0]             pkt_mode_r;
   logic [MD_WIDTH-1:0]    md_r;
   logic                   drop_r;

   logic [MD_WIDTH-1:0]    md_first_s;
   logic                   drop_first_s;
   logic [1:0]             mode_cur_s;
   logic [MD_WIDTH-1:0]    md_cur_s;
   logic                   drop_cur_s;
   logic [USER_WIDTH-1:0]  user_s;

   logic                   accept_s;
   logic                   push_s;
   logic                   out_fire_s;
   logic                   skid_ready_s;
   logic [PAYLOAD_WIDTH-1:0] skid_in_s;
   logic [PAYLOAD_WIDTH-1:0] skid_out_s;

   logic [CNT_WIDTH-1:0]   pkt_cnt_r;
   logic [CNT_WIDTH-1:0]   drop_cnt_r;
   logic [CNT_WIDTH-1:0]   byte_cnt_r;

   // Metadata candidate from the current input beat; bytes not covered by tkeep are zeroed.
   always_comb begin
      md_first_s = {MD_WIDTH{1'b0}};
      for (int i = 0; i < MD_BYTES; i++) begin
         if (s_axis_tkeep[MD_OFFSET + i]) begin
            md_first_s[i*8 +: 8] = s_axis_tdata[(MD_OFFSET + i)*8 +: 8];
         end else begin
            md_first_s[i*8 +: 8] = 8'h00;
         end
      end
      drop_first_s = mode_drops(cfg_mode) && (md_first_s == {MD_WIDTH{1'b0}});
   end

   // Packet context for the beat on the input: live values on a first beat, latched ones after.
   always_comb begin
      mode_cur_s = pkt_mode_r;
      md_cur_s   = md_r;
      drop_cur_s = drop_r;
      if (state_r == ST_FIRST) begin
         mode_cur_s = cfg_mode;
         md_cur_s   = md_first_s;
         drop_cur_s = drop_first_s;
      end else begin
         mode_cur_s = pkt_mode_r;
         md_cur_s   = md_r;
         drop_cur_s = drop_r;
      end
   end

   // tuser rewrite: splice md into its bit-field unless the packet is pass-through.
   always_comb begin
      user_s = s_axis_tuser;
      if (mode_inserts(mode_cur_s)) begin
         user_s[MD_USER_LSB +: MD_WIDTH] = md_cur_s;
      end else begin
         user_s = s_axis_tuser;
      end
   end

   assign accept_s   = s_axis_tvalid && skid_ready_s;
   // Dropped beats are consumed upstream but never reach the output path.
   assign push_s     = accept_s && !drop_cur_s;
   assign out_fire_s = m_axis_tvalid && m_axis_tready;

   // Packet-boundary tracking: leave FIRST on a non-last first beat, return on tlast.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         ST_FIRST: begin
            if (accept_s && !s_axis_tlast) begin
               state_n_s = ST_MIDDLE;
            end else begin
               state_n_s = ST_FIRST;
            end
         end
         ST_MIDDLE: begin
            if (accept_s && s_axis_tlast) begin
               state_n_s = ST_FIRST;
            end else begin
               state_n_s = ST_MIDDLE;
            end
         end
         default: begin
            state_n_s = ST_FIRST;
         end
      endcase
   end

   // State register; reset discards any in-flight packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_FIRST;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Per-packet context captured on the accepted first beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_mode_r <= MD_MODE_PASS;
         md_r       <= {MD_WIDTH{1'b0}};
         drop_r     <= 1'b0;
      end else if (accept_s && (state_r == ST_FIRST)) begin
         pkt_mode_r <= cfg_mode;
         md_r       <= md_first_s;
         drop_r     <= drop_first_s;
      end
   end

   assign skid_in_s = {s_axis_tdata, s_axis_tkeep, user_s, s_axis_tlast};

   axis_skid_reg #(
      .WIDTH (PAYLOAD_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   (skid_in_s),
      .in_valid  (s_axis_tvalid && !drop_cur_s),
      .in_ready  (skid_ready_s),
      .out_data  (skid_out_s),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

   assign s_axis_tready = skid_ready_s;
   assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = skid_out_s;

   // Statistics: forwarded packets/bytes on output handshake, drops on the dropped tlast beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt_r  <= {CNT_WIDTH{1'b0}};
         drop_cnt_r <= {CNT_WIDTH{1'b0}};
         byte_cnt_r <= {CNT_WIDTH{1'b0}};
      end else begin
         if (out_fire_s) begin
            byte_cnt_r <= byte_cnt_r + keep_popcount(m_axis_tkeep);
            if (m_axis_tlast) begin
               pkt_cnt_r <= pkt_cnt_r + CNT_WIDTH'(1);
            end
         end
         if (accept_s && drop_cur_s && s_axis_tlast) begin
            drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
         end
      end
   end

   assign stat_pkt_cnt  = pkt_cnt_r;
   assign stat_drop_cnt = drop_cnt_r;
   assign stat_byte_cnt = byte_cnt_r;

   // push_s documents the output-path condition; the skid derives it from in_valid && in_ready.
   logic unused_push_s;
   assign unused_push_s = push_s;

endmodule

// File: tb/tb_md_process_pipe.sv
module tb_md_process_pipe;

   localparam int DW = 128;
   localparam int KW = 16;
   localparam int UW = 64;
   localparam int CW = 32;
   localparam int N  = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic [UW-1:0] s_tuser;
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tlast;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic [UW-1:0] m_tuser;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;
   logic [1:0]    cfg_mode;
   logic [CW-1:0] pkt_cnt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] byte_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   md_process_pipe #(
      .DATA_WIDTH (DW), .USER_WIDTH (UW), .MD_OFFSET (2),
      .MD_WIDTH (32), .MD_USER_LSB (0), .CNT_WIDTH (CW)
   ) dut (
      .clk (clk), .rst (rst),
      .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
      .s_axis_tvalid (s_tvalid), .s_axis_tready (s_tready), .s_axis_tlast (s_tlast),
      .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tuser (m_tuser),
      .m_axis_tvalid (m_tvalid), .m_axis_tready (m_tready), .m_axis_tlast (m_tlast),
      .cfg_mode (cfg_mode),
      .stat_pkt_cnt (pkt_cnt), .stat_drop_cnt (drop_cnt), .stat_byte_cnt (byte_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = {DW{1'b0}};
      s_tkeep  = {KW{1'b0}};
      s_tuser  = {UW{1'b0}};
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic [UW-1:0] u, input logic l);
      s_tdata  = d;
      s_tkeep  = k;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      m_tready = 1'b1;
      cfg_mode = 2'd0;
      tick();
      tick();
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
      n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b expected 0", s_tready); end
      n_cmp++; if ({pkt_cnt, drop_cnt, byte_cnt} !== {3*CW{1'b0}}) begin n_err++; $display("FAIL reset_counters: got %h %h %h expected 0 0 0", pkt_cnt, drop_cnt, byte_cnt); end
      n_cmp++; if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== {(DW+KW+UW+1){1'b0}}) begin n_err++; $display("FAIL reset_payload: got %h %h %h %b expected zeros", m_tdata, m_tkeep, m_tuser, m_tlast); end
      rst = 1'b0;
      tick();
      n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL reset_release_tready: got %b expected 1", s_tready); end
   endtask

   task automatic test_insert;
      logic [DW-1:0] d0, d1, d2;
      d0 = 128'h0123_4567_89AB_CDEF_0011_DEAD_BEEF_A5A5;
      d1 = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
      d2 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
      do_reset();
      cfg_mode = 2'd1;
      m_tready = 1'b1;
      send(d0, 16'hFFFF, 64'h1111_2222_3333_4444, 1'b0);
      tick();
      n_cmp++; if (m_tvalid !== 1'b1) begin n_err++; $display("FAIL insert_latency: tvalid got %b expected 1", m_tvalid); end
      n_cmp++; if (m_tdata !== d0) begin n_err++; $display("FAIL insert_b0_data: got %h expected %h", m_tdata, d0); end
      n_cmp++; if (m_tuser !== 64'h1111_2222_DEAD_BEEF) begin n_err++; $display("FAIL insert_b0_user: got %h expected 1111_2222_deadbeef", m_tuser); end
      send(d1, 16'hFFFF, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
      tick();
      n_cmp++; if ({m_tdata, m_tuser, m_tlast} !== {d1, 64'hAAAA_BBBB_DEAD_BEEF, 1'b0}) begin n_err++; $display("FAIL insert_b1: got %h %h %b expected %h aaaabbbbdeadbeef 0", m_tdata, m_tuser, m_tlast, d1); end
      send(d2, 16'h0FFF, 64'h0, 1'b1);
      tick();
      n_cmp++; if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== {d2, 16'h0FFF, 64'h0000_0000_DEAD_BEEF, 1'b1}) begin n_err++; $display("FAIL insert_b2: got %h %h %h %b", m_tdata, m_tkeep, m_tuser, m_tlast); end
      idle_inputs();
      tick();
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL insert_drain: tvalid got %b expected 0", m_tvalid); end
      n_cmp++; if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL insert_pkt_cnt: got %0d expected 1", pkt_cnt); end
      n_cmp++; if (byte_cnt !== 32'd44) begin n_err++; $display("FAIL insert_byte_cnt: got %0d expected 44", byte_cnt); end
   endtask

   task automatic test_drop;
      logic [DW-1:0] b0;
      b0 = 128'h0000_0000_0000_0000_0000_0000_0001_7777;
      do_reset();
      cfg_mode = 2'd2;
      m_tready = 1'b1;
      send(128'h0123_4567_89AB_CDEF_5555_0000_0000_1234, 16'hFFFF, 64'h9, 1'b0);
      tick();
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL drop_a0_tvalid: got %b expected 0", m_tvalid); end
      send(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'hFFFF, 64'h9, 1'b1);
      tick();
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL drop_a1_tvalid: got %b expected 0", m_tvalid); end
      n_cmp++; if (drop_cnt !== 32'd1) begin n_err++; $display("FAIL drop_cnt_after_a: got %0d expected 1", drop_cnt); end
      send(b0, 16'h00FF, 64'hFFFF_0000_FFFF_0000, 1'b1);
      tick();
      n_cmp++; if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, b0, 64'hFFFF_0000_0000_0001}) begin n_err++; $display("FAIL drop_b0: got %b %h %h expected 1 %h ffff000000000001", m_tvalid, m_tdata, m_tuser, b0); end
      idle_inputs();
      tick();
      n_cmp++; if ({pkt_cnt, drop_cnt, byte_cnt} !== {32'd1, 32'd1, 32'd8}) begin n_err++; $display("FAIL drop_stats: got %0d %0d %0d expected 1 1 8", pkt_cnt, drop_cnt, byte_cnt); end
   endtask

   task automatic test_short_keep;
      logic [DW-1:0] d;
      d = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_DEAD_BEEF_1234;
      do_reset();
      cfg_mode = 2'd1;
      m_tready = 1'b1;
      send(d, 16'h000F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      tick();
      n_cmp++; if ({m_tdata, m_tkeep, m_tuser} !== {d, 16'h000F, 64'hFFFF_FFFF_0000_BEEF}) begin n_err++; $display("FAIL short_keep_md: got %h %h %h expected ffffffff0000beef", m_tdata, m_tkeep, m_tuser); end
      // Only masked bytes are non-zero: md reads as zero and the packet is dropped.
      cfg_mode = 2'd2;
      send(128'h0000_0000_0000_0000_0000_DEAD_0000_1234, 16'h000F, 64'h0, 1'b1);
      tick();
      idle_inputs();
      n_cmp++; if ({m_tvalid, drop_cnt} !== {1'b0, 32'd1}) begin n_err++; $display("FAIL short_keep_drop: got tvalid %b drops %0d expected 0 1", m_tvalid, drop_cnt); end
   endtask

   task automatic test_mode_switch;
      logic [DW-1:0] d0;
      d0 = 128'h1111_2222_3333_4444_5555_CAFE_F00D_0000;
      do_reset();
      cfg_mode = 2'd1;
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) cfg_mode = 2'd0;
         send((i == 0) ? d0 : {8{16'(i)}}, 16'hFFFF, 64'h0123_4567_89AB_CDEF, (i == 3));
         tick();
         n_cmp++; if (m_tuser !== 64'h0123_4567_CAFE_F00D) begin n_err++; $display("FAIL mode_switch_beat%0d: got %h expected 01234567cafef00d", i, m_tuser); end
      end
      send(d0, 16'hFFFF, 64'h0123_4567_89AB_CDEF, 1'b1);
      tick();
      idle_inputs();
      n_cmp++; if ({m_tvalid, m_tuser} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin n_err++; $display("FAIL mode_switch_next: got %b %h expected 1 0123456789abcdef", m_tvalid, m_tuser); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      cfg_mode = 2'd1;
      m_tready = 1'b1;
      send(128'h0000_0000_0000_0000_0000_1111_1111_0000, 16'hFFFF, 64'h0, 1'b0);
      tick();
      n_cmp++; if (m_tuser !== 64'h0000_0000_1111_1111) begin n_err++; $display("FAIL reset_mid_b0: got %h expected 0000000011111111", m_tuser); end
      send(128'h0000_0000_0000_0000_0000_3333_3333_0000, 16'hFFFF, 64'h0, 1'b0);
      rst = 1'b1;
      tick();
      n_cmp++; if ({m_tvalid, pkt_cnt, byte_cnt, s_tready} !== {1'b0, 32'd0, 32'd0, 1'b0}) begin n_err++; $display("FAIL reset_mid_clear: got %b %0d %0d %b expected 0 0 0 0", m_tvalid, pkt_cnt, byte_cnt, s_tready); end
      rst = 1'b0;
      idle_inputs();
      tick();
      send(128'h0000_0000_0000_0000_0000_2222_2222_0000, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      tick();
      n_cmp++; if ({m_tvalid, m_tuser} !== {1'b1, 64'hFFFF_FFFF_2222_2222}) begin n_err++; $display("FAIL reset_mid_newfirst: got %b %h expected 1 ffffffff22222222", m_tvalid, m_tuser); end
      idle_inputs();
      tick();
      n_cmp++; if ({pkt_cnt, byte_cnt} !== {32'd1, 32'd16}) begin n_err++; $display("FAIL reset_mid_stats: got %0d %0d expected 1 16", pkt_cnt, byte_cnt); end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] bd [N];
      logic [KW-1:0] bk [N];
      logic [UW-1:0] bu [N];
      logic          bl [N];
      logic [3:0]    rp;
      logic          acc, emit, fill;
      int            sent, rcv, cyc;
      rp = 4'b1001;
      for (int i = 0; i < N; i++) begin
         bd[i] = {$urandom, $urandom, $urandom, $urandom};
         bu[i] = {$urandom, $urandom};
         bl[i] = ((i % 3) == 2);
         bk[i] = bl[i] ? 16'h00FF : 16'hFFFF;
      end
      do_reset();
      cfg_mode = 2'd0;
      sent = 0; rcv = 0; cyc = 0;
      while ((rcv < N) && (cyc < 500)) begin
         if (sent < N) send(bd[sent], bk[sent], bu[sent], bl[sent]);
         else idle_inputs();
         m_tready = (cyc < 4) ? rp[cyc] : 1'($urandom_range(0, 1));
         acc  = s_tvalid && s_tready;
         emit = m_tvalid && m_tready;
         fill = acc && m_tvalid && !m_tready;
         if (emit) begin
            n_cmp++;
            if (rcv >= N) begin
               n_err++; $display("FAIL b2b_extra_beat: got beat %0d expected at most %0d", rcv, N);
            end else if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== {bd[rcv], bk[rcv], bu[rcv], bl[rcv]}) begin
               n_err++; $display("FAIL b2b_beat%0d: got %h %h %h %b expected %h %h %h %b", rcv, m_tdata, m_tkeep, m_tuser, m_tlast, bd[rcv], bk[rcv], bu[rcv], bl[rcv]);
            end
            rcv++;
         end
         tick();
         if (acc) sent++;
         if (fill) begin
            n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL b2b_skid_tready: got %b expected 0 at cycle %0d", s_tready, cyc); end
         end
         cyc++;
      end
      idle_inputs();
      n_cmp++; if (rcv != N) begin n_err++; $display("FAIL b2b_timeout: got %0d beats expected %0d", rcv, N); end
      n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL b2b_no_dup: tvalid got %b expected 0", m_tvalid); end
      n_cmp++; if ({pkt_cnt, byte_cnt} !== {32'd8, 32'd320}) begin n_err++; $display("FAIL b2b_stats: got %0d %0d expected 8 320", pkt_cnt, byte_cnt); end
      m_tready = 1'b1;
   endtask

   initial begin
      rst      = 1'b1;
      m_tready = 1'b1;
      cfg_mode = 2'd0;
      idle_inputs();
      test_reset();
      test_insert();
      test_drop();
      test_short_keep();
      test_mode_switch();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
